adaptive_filter_out_buf: RTL and testbench
==========================================

Name: adaptive_filter_out_buf

Overview:
- Output buffer directly downstream of the adaptive filter core.
- Captures the core's free-running Q8.6 output stream (valid only, no backpressure) into a circular FIFO.
- Re-presents the samples as a valid/ready stream so consumers can stall without losing data.
- Counts dropped samples and can be flushed when the filter mode (ctrl) changes.

Parameters:
- DATA_WIDTH, 14: sample width, signed Q8.6 (bits [7:-6]).
- DEPTH, 16: FIFO entries; power of two, 2..256.
- CNT_WIDTH, 16: width of the drop counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- arst_n  in  1  asynchronous active-low reset. Asserts immediately; deasserts synchronously to clk.
- flush  in  1  synchronous FIFO clear, pulse one cycle.
- s_tdata  in  [7:-6]  filter output sample.
- s_tvalid  in  1  sample qualifier. No ready: the upstream cannot stall.
- m_tdata  out  [7:-6]  head-of-FIFO sample.
- m_tvalid  out  1  FIFO not empty.
- m_tready  in  1  consumer accepts the head sample.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf and drop_cnt.
- drop_cnt  out  CNT_WIDTH  saturating count of dropped samples.

Behaviour:
- Reset (arst_n=0): wr_ptr=rd_ptr=0, level=0, m_tvalid=0, full=0, ovf=0, drop_cnt=0, m_tdata=0. Storage contents are don't-care.
- Handshakes:
  - push = s_tvalid && (!full || pop).
  - pop = m_tvalid && m_tready.
- Occupancy update (registered):
  - push only: level+1.
  - pop only: level-1.
  - push and pop together: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. level is held in a separate counter so empty and full are never ambiguous.
- Latency:
  - A sample pushed in cycle N drives m_tdata with m_tvalid=1 in cycle N+1, given it is at the head.
  - No combinational path from s_tvalid to m_tvalid.
- m_tdata = mem[rd_ptr] whenever m_tvalid=1. It holds the same value while m_tvalid && !m_tready (stream stability rule).
- Empty with s_tvalid: the sample is written, and m_tvalid rises the next cycle.
- Full:
  - s_tvalid with m_tready=1: sample accepted (pop frees a slot in the same cycle).
  - s_tvalid with m_tready=0: sample dropped, ovf<=1, drop_cnt increments and saturates at all-ones.
- ovf_clr: next cycle ovf=0 and drop_cnt=0. If a drop occurs in the same cycle, the drop wins: ovf=1, drop_cnt=1.
- flush:
  - Next cycle level=0, pointers=0, m_tvalid=0.
  - A push in the flush cycle is discarded and does not count as a drop.
  - ovf and drop_cnt are unaffected.
- Data is stored bit-exact: no rounding, no saturation, sign preserved.
- arst_n asserted mid-transfer: all state returns to reset values immediately, and no partial sample survives.

Test Plan:
- Write path: reset, then push 0x0040 (+1.0), 0x3FC0 (-1.0), 0x1FFF with m_tready=1 → m_tvalid appears one cycle after each push, outputs in the same order, level returns to 0.
- Overflow: DEPTH=16, m_tready=0, 20 consecutive pushes of values 1..20 → full=1 after 16, ovf=1, drop_cnt=4. Draining then yields 1..16 only.
- Full boundary: FIFO full, s_tvalid=1 and m_tready=1 in the same cycle → no drop, level stays 16, and the new sample appears 16 pops later.
- Stall stability: m_tready toggled pseudo-randomly against continuous input → m_tdata is stable while stalled, there is no loss while level<16, and a scoreboard matches.
- Flush and clear: level=5 → flush → level=0 and m_tvalid=0 next cycle, ovf kept. ovf_clr in the same cycle as a drop → ovf=1, drop_cnt=1.
- Async reset: assert arst_n mid-stream, off the clock edge → outputs go to 0 before the next edge, and the stream restarts cleanly after deassertion.

Source files
------------

// File: rtl/adaptive_filter_out_buf_if.sv
// Sample stream bundle between the filter core, the output buffer and its consumer.
// The upstream half (s_*) carries no ready: the filter core cannot be stalled.
interface adaptive_filter_out_buf_if #(
    parameter int DATA_WIDTH = 14
);
    logic [DATA_WIDTH-7:-6] s_tdata;
    logic                   s_tvalid;
    logic [DATA_WIDTH-7:-6] m_tdata;
    logic                   m_tvalid;
    logic                   m_tready;

    modport master (
        output s_tdata,
        output s_tvalid,
        input  m_tdata,
        input  m_tvalid,
        output m_tready
    );

    modport slave (
        input  s_tdata,
        input  s_tvalid,
        output m_tdata,
        output m_tvalid,
        input  m_tready
    );
endinterface

// File: rtl/adaptive_filter_out_buf.sv
// Circular FIFO turning the free-running Q8.6 filter output into a valid/ready stream.
// One cycle push-to-valid; when full and stalled, new samples are dropped and counted.
module adaptive_filter_out_buf #(
    parameter int DATA_WIDTH = 14,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       flush,
    adaptive_filter_out_buf_if.slave   bus,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       ovf,
    input  logic                       ovf_clr,
    output logic [CNT_WIDTH-1:0]       drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [1:0]             rst_sync;
    logic                   rst_n;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [DATA_WIDTH-7:-6] mem [DEPTH];
    logic                   push;
    logic                   pop;
    logic                   drop;

    // Reset asserts asynchronously but is released only on a clock edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    assign full         = (level == DEPTH_L);
    assign bus.m_tvalid = (level != '0);
    assign bus.m_tdata  = bus.m_tvalid ? mem[rd_ptr] : '0;

    assign pop  = bus.m_tvalid && bus.m_tready;
    assign push = bus.s_tvalid && (!full || pop);
    // A sample arriving with flush is discarded, never counted as lost.
    assign drop = bus.s_tvalid && full && !pop && !flush;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= bus.s_tdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_clr) begin
                drop_cnt <= CNT_WIDTH'(1);
            end else if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (ovf_clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_adaptive_filter_out_buf.sv
// Scoreboard bench for adaptive_filter_out_buf: a queue model predicts every output each cycle.
module tb_adaptive_filter_out_buf;
    localparam int DEPTH = 16;

    logic        clk;
    logic        arst_n;
    logic        flush;
    logic        ovf_clr;
    logic [4:0]  level;
    logic        full;
    logic        ovf;
    logic [15:0] drop_cnt;

    adaptive_filter_out_buf_if #(.DATA_WIDTH(14)) bus ();

    adaptive_filter_out_buf #(
        .DATA_WIDTH(14),
        .DEPTH(DEPTH),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .flush(flush),
        .bus(bus),
        .level(level),
        .full(full),
        .ovf(ovf),
        .ovf_clr(ovf_clr),
        .drop_cnt(drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          total = 0;
    int          bad   = 0;
    logic [7:-6] q [$];
    logic        mdl_ovf = 1'b0;
    logic [15:0] mdl_cnt = '0;

    // One cycle: drive inputs just after negedge, predict, clock, compare at next negedge.
    task automatic step(input logic v, input logic [7:-6] d, input logic r,
                        input logic fl, input logic clr);
        logic        pop_m;
        logic        push_m;
        logic        drop_m;
        logic [7:-6] exp_dat;
        bus.s_tvalid = v;
        bus.s_tdata  = d;
        bus.m_tready = r;
        flush        = fl;
        ovf_clr      = clr;
        #1;
        pop_m  = (q.size() != 0) && r;
        push_m = v && ((q.size() < DEPTH) || pop_m);
        drop_m = v && (q.size() == DEPTH) && !pop_m && !fl;
        if (pop_m) begin
            total++;
            if (bus.m_tdata !== q[0]) begin
                bad++;
                $display("FAIL pop_data got=%h exp=%h t=%0t", bus.m_tdata, q[0], $time);
            end
            void'(q.pop_front());
        end
        if (fl) q.delete();
        else if (push_m) q.push_back(d);
        if (drop_m) begin
            mdl_ovf = 1'b1;
            mdl_cnt = clr ? 16'd1 : ((mdl_cnt == 16'hFFFF) ? mdl_cnt : mdl_cnt + 16'd1);
        end else if (clr) begin
            mdl_ovf = 1'b0;
            mdl_cnt = '0;
        end
        @(posedge clk);
        @(negedge clk);
        exp_dat = (q.size() != 0) ? q[0] : '0;
        total += 6;
        if (bus.m_tvalid !== (q.size() != 0)) begin
            bad++; $display("FAIL m_tvalid got=%b exp=%b t=%0t", bus.m_tvalid, (q.size() != 0), $time);
        end
        if (level !== 5'(q.size())) begin
            bad++; $display("FAIL level got=%0d exp=%0d t=%0t", level, q.size(), $time);
        end
        if (full !== (q.size() == DEPTH)) begin
            bad++; $display("FAIL full got=%b exp=%b t=%0t", full, (q.size() == DEPTH), $time);
        end
        if (ovf !== mdl_ovf) begin
            bad++; $display("FAIL ovf got=%b exp=%b t=%0t", ovf, mdl_ovf, $time);
        end
        if (drop_cnt !== mdl_cnt) begin
            bad++; $display("FAIL drop_cnt got=%0d exp=%0d t=%0t", drop_cnt, mdl_cnt, $time);
        end
        if (bus.m_tdata !== exp_dat) begin
            bad++; $display("FAIL head_data got=%h exp=%h t=%0t", bus.m_tdata, exp_dat, $time);
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        bus.s_tvalid = 1'b0; bus.s_tdata = '0; bus.m_tready = 1'b0;
        flush = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({bus.m_tvalid, full, ovf, level, drop_cnt, bus.m_tdata} !== '0) begin
            bad++;
            $display("FAIL reset_state got vld=%b full=%b ovf=%b lvl=%0d cnt=%0d dat=%h exp all zero",
                     bus.m_tvalid, full, ovf, level, drop_cnt, bus.m_tdata);
        end
        @(negedge clk);
        arst_n = 1'b1;
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_write_path();
        logic [7:-6] vals [3];
        vals[0] = 14'h0040; vals[1] = 14'h3FC0; vals[2] = 14'h1FFF;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, vals[i], 1'b1, 1'b0, 1'b0);
            total++;
            if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== vals[i]) begin
                bad++;
                $display("FAIL write_latency got vld=%b dat=%h exp vld=1 dat=%h",
                         bus.m_tvalid, bus.m_tdata, vals[i]);
            end
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        total++;
        if (level !== 5'd0) begin
            bad++; $display("FAIL write_level_end got=%0d exp=0", level);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 14'(i), 1'b0, 1'b0, 1'b0);
            if (i == 16) begin
                total++;
                if (full !== 1'b1) begin
                    bad++; $display("FAIL ovfl_full_at_16 got=%b exp=1", full);
                end
            end
        end
        total++;
        if (ovf !== 1'b1 || drop_cnt !== 16'd4 || level !== 5'd16) begin
            bad++;
            $display("FAIL ovfl_counts got ovf=%b cnt=%0d lvl=%0d exp ovf=1 cnt=4 lvl=16",
                     ovf, drop_cnt, level);
        end
        repeat (16) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        total++;
        if (ovf !== 1'b0 || drop_cnt !== 16'd0) begin
            bad++; $display("FAIL ovf_clr got ovf=%b cnt=%0d exp 0/0", ovf, drop_cnt);
        end
    endtask

    task automatic test_full_boundary();
        for (int i = 0; i < 16; i++) step(1'b1, 14'(100 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 14'h0AAA, 1'b1, 1'b0, 1'b0);
        total++;
        if (level !== 5'd16 || drop_cnt !== 16'd0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL full_push_pop got lvl=%0d cnt=%0d ovf=%b exp 16/0/0", level, drop_cnt, ovf);
        end
        repeat (15) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        total++;
        if (bus.m_tdata !== 14'h0AAA || level !== 5'd1) begin
            bad++;
            $display("FAIL full_new_last got dat=%h lvl=%0d exp 0aaa/1", bus.m_tdata, level);
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 14'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
        end
        repeat (DEPTH + 1) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        total++;
        if (level !== 5'd0) begin
            bad++; $display("FAIL stall_drain got=%0d exp=0", level);
        end
    endtask

    task automatic test_flush_clear();
        for (int i = 0; i < 17; i++) step(1'b1, 14'(200 + i), 1'b0, 1'b0, 1'b0);
        repeat (11) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        total++;
        if (level !== 5'd5) begin
            bad++; $display("FAIL flush_pre_level got=%0d exp=5", level);
        end
        step(1'b1, 14'h0123, 1'b0, 1'b1, 1'b0);
        total++;
        if (level !== 5'd0 || bus.m_tvalid !== 1'b0 || ovf !== 1'b1 || drop_cnt !== 16'd1) begin
            bad++;
            $display("FAIL flush got lvl=%0d vld=%b ovf=%b cnt=%0d exp 0/0/1/1",
                     level, bus.m_tvalid, ovf, drop_cnt);
        end
        for (int i = 0; i < 17; i++) step(1'b1, 14'(300 + i), 1'b0, 1'b0, 1'b0);
        total++;
        if (drop_cnt !== 16'd2) begin
            bad++; $display("FAIL drop_accum got=%0d exp=2", drop_cnt);
        end
        step(1'b1, 14'h0555, 1'b0, 1'b0, 1'b1);
        total++;
        if (ovf !== 1'b1 || drop_cnt !== 16'd1) begin
            bad++; $display("FAIL clr_vs_drop got ovf=%b cnt=%0d exp 1/1", ovf, drop_cnt);
        end
        repeat (16) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 14'(400 + i), (i > 3), 1'b0, 1'b0);
        bus.s_tvalid = 1'b1; bus.s_tdata = 14'h0777; bus.m_tready = 1'b0;
        #3;
        arst_n = 1'b0;
        #1;
        total++;
        if (bus.m_tvalid !== 1'b0 || level !== 5'd0 || bus.m_tdata !== 14'h0000 || full !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got vld=%b lvl=%0d dat=%h full=%b exp all zero",
                     bus.m_tvalid, level, bus.m_tdata, full);
        end
        q.delete();
        mdl_ovf = 1'b0;
        mdl_cnt = '0;
        bus.s_tvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 14'(500 + i), 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        total++;
        if (level !== 5'd0 || bus.m_tvalid !== 1'b0) begin
            bad++; $display("FAIL restart_drain got lvl=%0d vld=%b exp 0/0", level, bus.m_tvalid);
        end
    endtask

    initial begin
        test_reset();
        test_write_path();
        test_overflow();
        test_full_boundary();
        test_stall();
        test_flush_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
